// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command bundle between the UART, the frame parser and the car controller.
// The parser takes the slave modport; whatever feeds it bytes takes the master modport.
interface uart_cmd_parser_if;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        tx_busy;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        csum_err;
  logic        frame_err;
  logic [7:0]  err_count;

  modport master (
    output received, rx_byte, recv_error, tx_busy,
    input  transmit, tx_byte, cmd_valid, cmd, arg, csum_err, frame_err, err_count
  );

  modport slave (
    input  received, rx_byte, recv_error, tx_busy,
    output transmit, tx_byte, cmd_valid, cmd, arg, csum_err, frame_err, err_count
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Turns UART bytes into 5-byte SYNC/CMD/ARG_HI/ARG_LO/CSUM command frames and answers
// every completed frame with an ACK or NAK byte through the UART transmitter.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_parser_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_ARG_HI,
    S_ARG_LO,
    S_CSUM
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       cmd_sh;
  logic [7:0]       arg_hi_sh;
  logic [7:0]       arg_lo_sh;
  logic             pending;

  logic             accept;
  logic             abort_err;
  logic             abort_tmo;
  logic             csum_ok;
  logic             cmd_valid_d;
  logic             csum_err_d;
  logic             frame_err_d;
  logic             queue_reply;
  logic [7:0]       reply_d;
  logic             send;

  // A byte that arrives together with a framing error is dropped.
  assign accept    = bus.received && !bus.recv_error;
  assign abort_err = bus.recv_error && (state != S_SYNC);
  assign abort_tmo = (state != S_SYNC) && !bus.received && !bus.recv_error && (tmo_cnt == CNT_LAST);
  assign csum_ok   = ((cmd_sh ^ arg_hi_sh ^ arg_lo_sh) == bus.rx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort_err || abort_tmo) begin
      state_next = S_SYNC;
    end else if (accept) begin
      unique case (state)
        S_SYNC:   state_next = (bus.rx_byte == SYNC_BYTE) ? S_CMD : S_SYNC;
        S_CMD:    state_next = S_ARG_HI;
        S_ARG_HI: state_next = S_ARG_LO;
        S_ARG_LO: state_next = S_CSUM;
        S_CSUM:   state_next = S_SYNC;
        default:  state_next = S_SYNC;
      endcase
    end
  end

  // A reply queued this cycle suppresses sending, so the newest reply is the one that goes out.
  always_comb begin
    cmd_valid_d = 1'b0;
    csum_err_d  = 1'b0;
    queue_reply = 1'b0;
    reply_d     = ACK_BYTE;
    frame_err_d = abort_err || abort_tmo;
    if (!frame_err_d && accept && (state == S_CSUM)) begin
      queue_reply = 1'b1;
      if (csum_ok) begin
        cmd_valid_d = 1'b1;
        reply_d     = ACK_BYTE;
      end else begin
        csum_err_d  = 1'b1;
        reply_d     = NAK_BYTE;
      end
    end
    send = pending && !bus.tx_busy && !queue_reply;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_sh    <= '0;
      arg_hi_sh <= '0;
      arg_lo_sh <= '0;
    end else if (accept) begin
      if (state == S_CMD)    cmd_sh    <= bus.rx_byte;
      if (state == S_ARG_HI) arg_hi_sh <= bus.rx_byte;
      if (state == S_ARG_LO) arg_lo_sh <= bus.rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (bus.received || abort_tmo || (state == S_SYNC)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.transmit  <= 1'b0;
      bus.tx_byte   <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= '0;
      bus.arg       <= '0;
      bus.csum_err  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
      pending       <= 1'b0;
    end else begin
      bus.transmit  <= send;
      bus.cmd_valid <= cmd_valid_d;
      bus.csum_err  <= csum_err_d;
      bus.frame_err <= frame_err_d;
      if (cmd_valid_d) begin
        bus.cmd <= cmd_sh;
        bus.arg <= {arg_hi_sh, arg_lo_sh};
      end
      if (queue_reply) begin
        pending     <= 1'b1;
        bus.tx_byte <= reply_d;
      end else if (send) begin
        pending <= 1'b0;
      end
      if ((csum_err_d || frame_err_d) && (bus.err_count != 8'hFF)) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames are sent byte by byte and outputs are compared
// against hand-computed values; a negedge monitor counts transmit pulses and captures reply bytes.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         tx_count     = 0;
  int         tx_back2back = 0;
  int         ferr_count   = 0;
  logic [7:0] last_tx      = 8'h00;
  logic       prev_tx      = 1'b0;

  always @(negedge clk) begin
    if (bus.transmit) begin
      tx_count <= tx_count + 1;
      last_tx  <= bus.tx_byte;
      if (prev_tx) tx_back2back <= tx_back2back + 1;
    end
    if (bus.frame_err) ferr_count <= ferr_count + 1;
    prev_tx <= bus.transmit;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one byte for one cycle; returns 1 ns after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.received = 1'b0;
  endtask

  task automatic pulseRecvError();
    @(posedge clk);
    #1;
    bus.recv_error = 1'b1;
    @(posedge clk);
    #1;
    bus.recv_error = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int base_tx;
  int base_ferr;

  initial begin
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.recv_error = 1'b0;
    bus.tx_busy    = 1'b0;

    idleCycles(3);
    checkOutput("reset transmit", {31'd0, bus.transmit}, 32'd0);
    checkOutput("reset tx_byte", {24'd0, bus.tx_byte}, 32'h00);
    checkOutput("reset cmd", {24'd0, bus.cmd}, 32'h00);
    checkOutput("reset arg", {16'd0, bus.arg}, 32'h0000);
    checkOutput("reset err_count", {24'd0, bus.err_count}, 32'd0);
    rst = 1'b0;

    // Good frame
    base_tx = tx_count;
    applyStimulus(8'hA5); applyStimulus(8'h10); applyStimulus(8'h01); applyStimulus(8'hF4);
    applyStimulus(8'hE5);
    checkOutput("good cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
    checkOutput("good cmd", {24'd0, bus.cmd}, 32'h10);
    checkOutput("good arg", {16'd0, bus.arg}, 32'h01F4);
    idleCycles(1);
    checkOutput("good cmd_valid one cycle", {31'd0, bus.cmd_valid}, 32'd0);
    idleCycles(4);
    checkOutput("good tx count", tx_count - base_tx, 32'd1);
    checkOutput("good tx byte", {24'd0, last_tx}, 32'h06);
    checkOutput("good err_count", {24'd0, bus.err_count}, 32'd0);

    // Bad checksum
    base_tx = tx_count;
    applyStimulus(8'hA5); applyStimulus(8'h10); applyStimulus(8'h01); applyStimulus(8'hF4);
    applyStimulus(8'h00);
    checkOutput("bad csum_err", {31'd0, bus.csum_err}, 32'd1);
    checkOutput("bad cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    checkOutput("bad cmd kept", {24'd0, bus.cmd}, 32'h10);
    checkOutput("bad arg kept", {16'd0, bus.arg}, 32'h01F4);
    idleCycles(4);
    checkOutput("bad tx count", tx_count - base_tx, 32'd1);
    checkOutput("bad tx byte", {24'd0, last_tx}, 32'h15);
    checkOutput("bad err_count", {24'd0, bus.err_count}, 32'd1);

    // Resync plus SYNC_BYTE as in-frame data
    base_tx = tx_count;
    applyStimulus(8'h33); applyStimulus(8'hA5); applyStimulus(8'hA5); applyStimulus(8'h00);
    applyStimulus(8'h01); applyStimulus(8'hA4);
    checkOutput("resync cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
    checkOutput("resync cmd", {24'd0, bus.cmd}, 32'hA5);
    checkOutput("resync arg", {16'd0, bus.arg}, 32'h0001);
    idleCycles(4);
    checkOutput("resync tx byte", {24'd0, last_tx}, 32'h06);
    checkOutput("resync tx count", tx_count - base_tx, 32'd1);

    // Timeout: frame_err exactly 100 cycles after the last accepted byte
    base_tx   = tx_count;
    base_ferr = ferr_count;
    applyStimulus(8'hA5); applyStimulus(8'h20);
    idleCycles(99);
    checkOutput("timeout not early", ferr_count - base_ferr, 32'd0);
    idleCycles(1);
    checkOutput("timeout frame_err", {31'd0, bus.frame_err}, 32'd1);
    idleCycles(4);
    checkOutput("timeout single pulse", ferr_count - base_ferr, 32'd1);
    checkOutput("timeout no tx", tx_count - base_tx, 32'd0);
    checkOutput("timeout err_count", {24'd0, bus.err_count}, 32'd2);
    applyStimulus(8'hA5); applyStimulus(8'h10); applyStimulus(8'h01); applyStimulus(8'hF4);
    applyStimulus(8'hE5);
    checkOutput("after timeout cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
    idleCycles(4);

    // Backpressure with reply overwrite
    bus.tx_busy = 1'b1;
    base_tx = tx_count;
    applyStimulus(8'hA5); applyStimulus(8'h20); applyStimulus(8'h12); applyStimulus(8'h34);
    applyStimulus(8'h06);
    applyStimulus(8'hA5); applyStimulus(8'h20); applyStimulus(8'h12); applyStimulus(8'h34);
    applyStimulus(8'h00);
    idleCycles(10);
    checkOutput("busy no tx", tx_count - base_tx, 32'd0);
    checkOutput("busy cmd", {24'd0, bus.cmd}, 32'h20);
    checkOutput("busy arg", {16'd0, bus.arg}, 32'h1234);
    bus.tx_busy = 1'b0;
    idleCycles(6);
    checkOutput("release tx count", tx_count - base_tx, 32'd1);
    checkOutput("release tx byte", {24'd0, last_tx}, 32'h15);
    checkOutput("release err_count", {24'd0, bus.err_count}, 32'd3);

    // Asynchronous reset mid-frame
    applyStimulus(8'hA5); applyStimulus(8'h10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset cmd", {24'd0, bus.cmd}, 32'h00);
    checkOutput("midreset arg", {16'd0, bus.arg}, 32'h0000);
    checkOutput("midreset tx_byte", {24'd0, bus.tx_byte}, 32'h00);
    checkOutput("midreset err_count", {24'd0, bus.err_count}, 32'd0);
    idleCycles(2);
    rst = 1'b0;

    // recv_error is ignored while hunting for SYNC, aborts a frame otherwise
    base_ferr = ferr_count;
    pulseRecvError();
    idleCycles(2);
    checkOutput("idle recv_error ignored", ferr_count - base_ferr, 32'd0);
    applyStimulus(8'hA5);
    pulseRecvError();
    checkOutput("recv_error frame_err", {31'd0, bus.frame_err}, 32'd1);
    checkOutput("recv_error err_count", {24'd0, bus.err_count}, 32'd1);
    idleCycles(3);
    checkOutput("recv_error single pulse", ferr_count - base_ferr, 32'd1);

    checkOutput("transmit never back-to-back", tx_back2back, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parses the byte stream delivered by the UART receiver into fixed 5-byte command frames for the car controller. Each valid frame produces a one-cycle command strobe with an 8-bit opcode and 16-bit argument. Every frame is answered with an ACK or NAK byte, sent back through the UART transmitter's transmit/tx_byte handshake.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- ACK_BYTE, 8'h06, reply for a good frame
- NAK_BYTE, 8'h15, reply for a checksum failure
- TIMEOUT_CYCLES, 5000000, max clk cycles between bytes inside a frame (100 ms at 50 MHz); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  master clock
- rst  in  1  reset, asynchronous, active-high
- received  in  1  one-cycle strobe: rx_byte is valid (from UART)
- rx_byte  in  8  received byte
- recv_error  in  1  one-cycle strobe: UART framing error
- tx_busy  in  1  UART is_transmitting
- transmit  out  1  one-cycle request to UART to send tx_byte
- tx_byte  out  8  reply byte; held stable while transmit is high
- cmd_valid  out  1  one-cycle strobe: cmd/arg hold a new command
- cmd  out  8  opcode of the last good frame
- arg  out  16  argument of the last good frame, {ARG_HI, ARG_LO}
- csum_err  out  1  one-cycle strobe: checksum mismatch
- frame_err  out  1  one-cycle strobe: frame aborted by recv_error or timeout
- err_count  out  8  saturating count of csum_err plus frame_err events

## Operation
- Frame layout: SYNC, CMD, ARG_HI, ARG_LO, CSUM, with CSUM = CMD ^ ARG_HI ^ ARG_LO.
- FSM states: S_SYNC, S_CMD, S_ARG_HI, S_ARG_LO, S_CSUM. Each state advances only on `received`.
  - S_SYNC: a byte equal to SYNC_BYTE goes to S_CMD. Any other byte is discarded and the FSM stays in S_SYNC.
  - S_CMD, S_ARG_HI and S_ARG_LO latch the byte into internal shadow registers and advance. SYNC_BYTE appearing here is ordinary data.
  - S_CSUM: the FSM always returns to S_SYNC.
    - On a match, cmd/arg are updated from the shadow registers, cmd_valid pulses, and an ACK reply is queued.
    - On a mismatch, csum_err pulses, a NAK reply is queued, and cmd/arg are unchanged.
- Timeout: the counter clears on every `received` and increments each cycle in any state other than S_SYNC. When it reaches TIMEOUT_CYCLES, frame_err pulses, the FSM goes to S_SYNC, and no reply is sent.
- recv_error in any state other than S_SYNC: frame_err pulses, the FSM goes to S_SYNC, and no reply is sent. In S_SYNC, recv_error is ignored.
- recv_error and received in the same cycle: recv_error wins and the byte is dropped.
- Reply queue: a single pending flag plus a reply byte.
  - Queuing a reply while one is still pending overwrites it, so the latest reply wins.
  - When pending is set and tx_busy is low, transmit pulses for one cycle with tx_byte set to the reply, and pending clears on the same edge.
- err_count increments by 1 for each csum_err or frame_err and saturates at 255. csum_err and frame_err never pulse in the same cycle.
- Reset (asynchronous, any state, mid-frame included):
  - FSM returns to S_SYNC; timeout counter and pending flag clear.
  - transmit=0, tx_byte=0, cmd_valid=0, cmd=0, arg=0, csum_err=0, frame_err=0, err_count=0.
  - A partially received frame is discarded.

## Timing
- Latency from `received` of the CSUM byte:
  - cmd_valid, csum_err and updated cmd/arg appear on the next rising edge (1 cycle).
- Latency to transmit:
  - Earliest transmit is 1 cycle after cmd_valid/csum_err (2 cycles after `received`), provided tx_busy is low.
  - While tx_busy is high, transmit stays low and pending holds.
- transmit is never high in two consecutive cycles. tx_byte changes only on the edge where a reply is queued.
- cmd and arg stay stable between cmd_valid pulses.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte of an incomplete frame.
- All strobes are registered outputs, each high for exactly one clk cycle.

## Test plan
- Good frame: send A5 10 01 F4 E5 -> one cmd_valid pulse with cmd=8'h10, arg=16'h01F4, then transmit once with tx_byte=8'h06; err_count=0.
- Bad checksum: send A5 10 01 F4 00 -> csum_err pulse, transmit with tx_byte=8'h15, cmd/arg keep their prior values, err_count=1.
- Resync and in-frame sync: send 33 A5 A5 00 01 A4 -> leading 33 discarded; frame decoded with cmd=8'hA5, arg=16'h0001, ACK sent.
- Timeout: with TIMEOUT_CYCLES=100, send A5 20 then idle 100 cycles -> frame_err pulses exactly 100 cycles after the 20 byte, no transmit; a following good frame is then accepted.
- Backpressure and overwrite: hold tx_busy=1, send a good frame then a bad-checksum frame, then release tx_busy -> a single transmit pulse with tx_byte=8'h15.
- Reset mid-frame plus recv_error: assert rst after A5 10 -> all outputs 0. Then send A5 followed by a recv_error pulse -> frame_err pulses and err_count=1.
